// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register addresses and FSM state encoding for the interrupt controller
package int_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;
  localparam logic [1:0] ADDR_IE     = 2'd0;
  localparam logic [1:0] ADDR_IP     = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: register bus, interrupt sources and irq handshake between core and int_ctrl
interface int_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 8,
  parameter int ID_WIDTH   = 3
);
  logic [NUM_SRC-1:0]    src;
  logic                  wr_en;
  logic                  rd_en;
  logic [1:0]            reg_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  irq_req;
  logic                  irq_ack;
  logic                  eoi;
  logic [DATA_WIDTH-1:0] interrupt;
  logic [ID_WIDTH-1:0]   grant_id;
  modport master (
    output src, wr_en, rd_en, reg_addr, wdata, irq_ack, eoi,
    input  rdata, irq_req, interrupt, grant_id
  );
  modport slave (
    input  src, wr_en, rd_en, reg_addr, wdata, irq_ack, eoi,
    output rdata, irq_req, interrupt, grant_id
  );
endinterface

// File: rtl/int_edge_det.sv
// int_edge_det: rising-edge detect on N sources; INT_CTRL_SYNC_EN adds a 2-flop synchronizer.
// History flops reset to 1 so a source already high out of reset does not fire.
module int_edge_det #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] src,
  output logic [N-1:0] rise
);
  logic [N-1:0] s_v, d_q;
`ifdef INT_CTRL_SYNC_EN
  logic [N-1:0] m_q, y_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '1;
      y_q <= '1;
    end else begin
      m_q <= src;
      y_q <= m_q;
    end
  end
  assign s_v = y_q;
`else
  assign s_v = src;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= '1;
    else        d_q <= s_v;
  end
  assign rise = s_v & ~d_q;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge-captured, prioritised interrupt controller with req/ack/eoi handshake.
// Define INT_CTRL_SYNC_EN to synchronise src before edge capture.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 8,
  parameter int ID_WIDTH   = 3
) (
  input logic       clk,
  input logic       rst_n,
  int_ctrl_if.slave bus
);
  logic [NUM_SRC-1:0]    rise, ie_q, ie_d, pend_q, pend_d, cand, clr, gnt_oh;
  logic                  ge_q, ge_d, req_q, req_d, ack, live;
  logic                  wr_ie, wr_ip, wr_ctrl;
  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   gid_q, gid_d, pick;
  logic [DATA_WIDTH-1:0] int_q, int_d, rdata_q, rdata_d, rd_mux;
  int_edge_det #(.N(NUM_SRC)) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .src  (bus.src),
    .rise (rise)
  );
  assign wr_ie   = bus.wr_en && bus.reg_addr == ADDR_IE;
  assign wr_ip   = bus.wr_en && bus.reg_addr == ADDR_IP;
  assign wr_ctrl = bus.wr_en && bus.reg_addr == ADDR_CTRL;
  assign cand    = ge_q ? pend_q & ie_q : '0;
  assign gnt_oh  = NUM_SRC'(1) << gid_q;
  assign ack     = state_q == REQ && bus.irq_ack;
  // a granted request stays live only while its source is still pending and enabled
  assign live    = ge_q && |(ie_q & pend_q & gnt_oh);
  always_comb begin
    pick = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (cand[i]) pick = ID_WIDTH'(i);
  end
  always_comb begin
    clr    = (wr_ip ? bus.wdata[NUM_SRC-1:0] : '0) | (ack ? gnt_oh : '0);
    pend_d = (pend_q & ~clr) | rise;
    ie_d   = wr_ie ? bus.wdata[NUM_SRC-1:0] : ie_q;
    ge_d   = wr_ctrl ? bus.wdata[0] : ge_q;
    rd_mux = bus.reg_addr == ADDR_IE   ? DATA_WIDTH'(ie_q)   :
             bus.reg_addr == ADDR_IP   ? DATA_WIDTH'(pend_q) :
             bus.reg_addr == ADDR_CTRL ? DATA_WIDTH'(ge_q)   :
                                         DATA_WIDTH'({state_q, gid_q});
    rdata_d = bus.rd_en ? rd_mux : rdata_q;
  end
  // ack is tested before the withdraw condition so it wins when both occur
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    int_d   = int_q;
    gid_d   = gid_q;
    if (state_q == IDLE && |cand) begin
      state_d = REQ;
      req_d   = 1'b1;
      gid_d   = pick;
      int_d   = DATA_WIDTH'(1) << pick;
    end else if (ack) begin
      state_d = SERVICE;
      req_d   = 1'b0;
    end else if (state_q == REQ && !live) begin
      state_d = IDLE;
      req_d   = 1'b0;
      int_d   = '0;
      gid_d   = '0;
    end else if (state_q == SERVICE && bus.eoi) begin
      state_d = IDLE;
      int_d   = '0;
      gid_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      int_q   <= '0;
      gid_q   <= '0;
      pend_q  <= '0;
      ie_q    <= '0;
      ge_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      int_q   <= int_d;
      gid_q   <= gid_d;
      pend_q  <= pend_d;
      ie_q    <= ie_d;
      ge_q    <= ge_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.rdata     = rdata_q;
  assign bus.irq_req   = req_q;
  assign bus.interrupt = int_q;
  assign bus.grant_id  = gid_q;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vector table, reset-in-service sequence, then random traffic vs a reference model
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  int_ctrl_if #(.DATA_WIDTH(8), .NUM_SRC(8), .ID_WIDTH(3)) bus ();
  int_ctrl #(.DATA_WIDTH(8), .NUM_SRC(8), .ID_WIDTH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  typedef struct {
    logic [7:0] src;
    logic       wr, rd;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       ack, eoi, req;
    logic [7:0] intr;
    logic [2:0] gid;
    logic       chk_rd;
    logic [7:0] rd_exp;
  } vec_t;
  vec_t tbl[$];
  // reference model state: mode 0=idle 1=requesting 2=in service
  logic [7:0] m_prev, m_pend, m_ie, m_rdata;
  logic       m_ge;
  int         m_mode, m_gid;
  function automatic vec_t v(logic [7:0] s, logic w, logic r, logic [1:0] a, logic [7:0] d,
                             logic k, logic e, logic q, logic [7:0] it, logic [2:0] g,
                             logic cr, logic [7:0] re);
    vec_t x;
    x.src = s; x.wr = w; x.rd = r; x.addr = a; x.wdata = d; x.ack = k; x.eoi = e;
    x.req = q; x.intr = it; x.gid = g; x.chk_rd = cr; x.rd_exp = re;
    return x;
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_prev = 8'hFF; m_pend = '0; m_ie = '0; m_ge = 1'b0;
    m_mode = 0; m_gid = 0; m_rdata = '0;
  endtask
  task automatic model(logic [7:0] s, logic w, logic r, logic [1:0] a, logic [7:0] d,
                       logic k, logic e);
    logic [7:0] rise, clr, cand, rv;
    int nm, ng;
    rise = s & ~m_prev;
    case (a)
      2'd0:    rv = m_ie;
      2'd1:    rv = m_pend;
      2'd2:    rv = {7'd0, m_ge};
      default: rv = 8'(m_mode * 8 + m_gid);
    endcase
    if (r) m_rdata = rv;
    clr = (w && a == 2'd1) ? d : 8'd0;
    if (m_mode == 1 && k) clr = clr | 8'(1 << m_gid);
    cand = m_ge ? (m_pend & m_ie) : 8'd0;
    nm = m_mode;
    ng = m_gid;
    if (m_mode == 0 && cand != 0) begin
      nm = 1;
      for (int i = 7; i >= 0; i--) if (cand[i]) ng = i;
    end else if (m_mode == 1 && k) nm = 2;
    else if (m_mode == 1 && !(m_ge && m_ie[m_gid] && m_pend[m_gid])) begin
      nm = 0; ng = 0;
    end else if (m_mode == 2 && e) begin
      nm = 0; ng = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (w && a == 2'd0) m_ie = d;
    if (w && a == 2'd2) m_ge = d[0];
    m_prev = s; m_mode = nm; m_gid = ng;
  endtask
  // apply inputs at the falling edge, clock once, land on the next falling edge
  task automatic step(logic [7:0] s, logic w, logic r, logic [1:0] a, logic [7:0] d,
                      logic k, logic e);
    bus.src = s; bus.wr_en = w; bus.rd_en = r; bus.reg_addr = a; bus.wdata = d;
    bus.irq_ack = k; bus.eoi = e;
    @(posedge clk);
    model(s, w, r, a, d, k, e);
    @(negedge clk);
  endtask
  initial begin
    vec_t t;
    // reset / register readback
    tbl.push_back(v(8'h00,0,1,2'd0,8'h00,0,0, 0,8'h00,0,1,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd1,8'h00,0,0, 0,8'h00,0,1,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd2,8'h00,0,0, 0,8'h00,0,1,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd3,8'h00,0,0, 0,8'h00,0,1,8'h00));
    // single source 3 through the full handshake
    tbl.push_back(v(8'h00,1,0,2'd0,8'hFF,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,1,0,2'd2,8'h01,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h08,0,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 1,8'h08,3,0,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd3,8'h00,0,0, 1,8'h08,3,1,8'h0B));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,1,0, 0,8'h08,3,0,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd1,8'h00,0,0, 0,8'h08,3,1,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd3,8'h00,0,0, 0,8'h08,3,1,8'h13));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,1, 0,8'h00,0,0,8'h00));
    // simultaneous 5 and 2: 2 first, then 5
    tbl.push_back(v(8'h24,0,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 1,8'h04,2,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,1,0, 0,8'h04,2,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,1, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 1,8'h20,5,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,1,0, 0,8'h20,5,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,1, 0,8'h00,0,0,8'h00));
    // masked source, late enable, W1C withdraw
    tbl.push_back(v(8'h00,1,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h02,0,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd1,8'h00,0,0, 0,8'h00,0,1,8'h02));
    tbl.push_back(v(8'h00,1,0,2'd0,8'h02,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 1,8'h02,1,0,8'h00));
    tbl.push_back(v(8'h00,1,0,2'd1,8'h02,0,0, 1,8'h02,1,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd1,8'h00,0,0, 0,8'h00,0,1,8'h00));
    // IE withdraw keeps pending
    tbl.push_back(v(8'h00,1,0,2'd0,8'h01,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h01,0,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 1,8'h01,0,0,8'h00));
    tbl.push_back(v(8'h00,1,0,2'd0,8'h00,0,0, 1,8'h01,0,0,8'h00));
    tbl.push_back(v(8'h00,0,0,2'd0,8'h00,0,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd1,8'h00,0,0, 0,8'h00,0,1,8'h01));
    // read+write same register returns old value, then re-grant of pending 0
    tbl.push_back(v(8'h00,1,1,2'd0,8'h55,0,0, 0,8'h00,0,1,8'h00));
    tbl.push_back(v(8'h00,0,1,2'd0,8'h00,0,0, 1,8'h01,0,1,8'h55));
    bus.src = '0; bus.wr_en = 0; bus.rd_en = 0; bus.reg_addr = '0; bus.wdata = '0;
    bus.irq_ack = 0; bus.eoi = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_irq_req", bus.irq_req, 0);
    chk("reset_interrupt", bus.interrupt, 0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      t = tbl[i];
      step(t.src, t.wr, t.rd, t.addr, t.wdata, t.ack, t.eoi);
      chk($sformatf("vec%0d_irq_req", i), bus.irq_req, t.req);
      chk($sformatf("vec%0d_interrupt", i), bus.interrupt, t.intr);
      if (t.intr != 0) chk($sformatf("vec%0d_grant_id", i), bus.grant_id, t.gid);
      if (t.chk_rd) chk($sformatf("vec%0d_rdata", i), bus.rdata, t.rd_exp);
    end
    // reset during service with a source held high
    step(8'h00, 0, 0, 2'd0, 8'h00, 1, 0);
    chk("svc_interrupt", bus.interrupt, 8'h01);
    step(8'h10, 0, 1, 2'd1, 8'h00, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq_req", bus.irq_req, 0);
    chk("arst_interrupt", bus.interrupt, 0);
    chk("arst_grant_id", bus.grant_id, 0);
    chk("arst_rdata", bus.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(8'h10, 1, 0, 2'd0, 8'hFF, 0, 0);
    step(8'h10, 1, 0, 2'd2, 8'h01, 0, 0);
    step(8'h10, 0, 0, 2'd0, 8'h00, 0, 0);
    step(8'h10, 0, 1, 2'd1, 8'h00, 0, 0);
    chk("held_src_ip", bus.rdata, 8'h00);
    chk("held_src_irq_req", bus.irq_req, 0);
    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [7:0] s;
      logic [1:0] a;
      logic w;
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : bus.src;
      w = $urandom_range(0, 7) == 0;
      a = 2'($urandom);
      step(s, w, $urandom_range(0, 3) == 0, a,
           (w && a == 2'd2) ? 8'($urandom_range(0, 7) != 0) : 8'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      chk("rand_irq_req", bus.irq_req, m_mode == 1);
      chk("rand_interrupt", bus.interrupt, m_mode != 0 ? 8'(1 << m_gid) : 8'd0);
      if (m_mode != 0) chk("rand_grant_id", bus.grant_id, m_gid);
      chk("rand_rdata", bus.rdata, m_rdata);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
